// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. One full-adder cell and a carry
// register process one operand bit per clock, LSB first, producing
// {cout, sum} = a + b + cin after WIDTH bit-steps.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] ps_next;

  // Full-adder cell on the current LSBs and the partial sum after this step.
  always_comb begin
    bit_s   = sa[0] ^ sb[0] ^ c;
    bit_c   = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    ps_next = ps >> 1;
    ps_next[WIDTH-1] = bit_s;
  end

  // Control FSM, operand/partial-sum shifters and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= cin;
            ps    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= bit_c;
          ps  <= ps_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            sum   <= ps_next;
            cout  <= bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random ops against
// an arithmetic model, multi-cycle corner sequences, exhaustive WIDTH=2.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8, start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  // WIDTH=2 instance
  logic       rst2, start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One add on the WIDTH=8 instance; lat = negedges after the start edge
  // until done is seen, bc = samples with busy high in that window.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output int lat, output int bc);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    bc  = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bc++;
      @(negedge clk);
      lat++;
    end
    s  = sum8;
    co = cout8;
  endtask

  task automatic add2(input logic [1:0] a, input logic [1:0] b, input logic c,
                      output logic [1:0] s, output logic co, output int lat);
    @(negedge clk);
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s  = sum2;
    co = cout2;
  endtask

  initial begin
    logic [7:0] s8;
    logic [1:0] s2;
    logic       co;
    int         lat, bc;
    logic [8:0] exp9;
    logic [2:0] exp3;
    int         ndone, first_k, d0, d1, bad_busy;
    logic [7:0] r_sum0, r_sum1;
    logic       r_co0, r_co1;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst2 = 1'b0;

    check("reset_sum8",  32'(sum8),  32'h0);
    check("reset_cout8", 32'(cout8), 32'h0);
    check("reset_busy8", 32'(busy8), 32'h0);
    check("reset_done8", 32'(done8), 32'h0);
    check("reset_sum2",  32'(sum2),  32'h0);

    // Directed table: result, latency and busy window
    for (int i = 0; i < 8; i++) begin
      add8(vecs[i].a, vecs[i].b, vecs[i].cin, s8, co, lat, bc);
      check($sformatf("vec%0d_sum", i),  32'(s8),  32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(co),  32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'd8);
      check($sformatf("vec%0d_busy", i), 32'(bc),  32'd8);
    end

    // Random operands against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp9 = 9'(ra) + 9'(rb) + 9'(rc);
      add8(ra, rb, rc, s8, co, lat, bc);
      check($sformatf("rand%0d_%02h_%02h_%0d", i, ra, rb, rc), 32'({co, s8}), 32'(exp9));
    end

    // Start during RUN must be ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; first_k = -1; r_sum0 = '0; r_co0 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k == 3) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1; end
      if (k == 4) start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (first_k < 0) begin first_k = k; r_sum0 = sum8; r_co0 = cout8; end
      end
      @(negedge clk);
    end
    check("busyprot_ndone", 32'(ndone),   32'd1);
    check("busyprot_lat",   32'(first_k), 32'd8);
    check("busyprot_sum",   32'(r_sum0),  32'h46);
    check("busyprot_cout",  32'(r_co0),   32'h0);

    // Back-to-back with start held: second op is sampled in the DONE cycle
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    ndone = 0; d0 = -1; d1 = -1; bad_busy = 0;
    r_sum0 = '0; r_sum1 = '0; r_co0 = 1'b0; r_co1 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) begin a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1; end
      if (k == 9) start8 = 1'b0;
      if (k <= 17 && (busy8 == done8)) bad_busy++;
      if (done8) begin
        ndone++;
        if (d0 < 0) begin d0 = k; r_sum0 = sum8; r_co0 = cout8; end
        else if (d1 < 0) begin d1 = k; r_sum1 = sum8; r_co1 = cout8; end
      end
      @(negedge clk);
    end
    check("b2b_ndone",    32'(ndone),    32'd2);
    check("b2b_d0",       32'(d0),       32'd8);
    check("b2b_d1_lat",   32'(d1 - d0 - 1), 32'd8);
    check("b2b_sum0",     32'(r_sum0),   32'h00);
    check("b2b_cout0",    32'(r_co0),    32'h1);
    check("b2b_sum1",     32'(r_sum1),   32'h04);
    check("b2b_cout1",    32'(r_co1),    32'h0);
    check("b2b_busy_gap", 32'(bad_busy), 32'd0);

    // Reset in the middle of bit-step 4, with a simultaneous start
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0; start8 = 1'b0;
    check("midrst_busy", 32'(busy8), 32'h0);
    check("midrst_done", 32'(done8), 32'h0);
    check("midrst_sum",  32'(sum8),  32'h0);
    check("midrst_cout", 32'(cout8), 32'h0);
    ndone = 0; bad_busy = 0;
    for (int k = 0; k < 15; k++) begin
      if (done8) ndone++;
      if (busy8) bad_busy++;
      @(negedge clk);
    end
    check("midrst_nodone", 32'(ndone),    32'd0);
    check("midrst_idle",   32'(bad_busy), 32'd0);
    add8(8'h01, 8'h01, 1'b0, s8, co, lat, bc);
    check("midrst_next_sum", 32'({co, s8}), 32'h002);

    // Exhaustive WIDTH=2
    for (int i = 0; i < 32; i++) begin
      logic [1:0] ea, eb;
      logic       ec;
      ea = 2'(i >> 3);
      eb = 2'(i >> 1);
      ec = 1'(i);
      exp3 = 3'(ea) + 3'(eb) + 3'(ec);
      add2(ea, eb, ec, s2, co, lat);
      check($sformatf("w2_%0d_%0d_%0d", ea, eb, ec), 32'({co, s2}), 32'(exp3));
      check($sformatf("w2_lat_%0d", i), 32'(lat), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
